// File: rtl/camera_value_pkg.sv
// camera_value_pkg: shared types and constants for the
// camera_value register programming master.
package camera_value_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int REG_STRIDE   = 4;
  localparam int DEF_NUM_REGS = 4;
  localparam int MAX_REGS     = 16;
  localparam int IDX_W        = 4;

  // Anything but a plain OKAY is treated as a failed access.
  function automatic logic resp_fail(input logic [1:0] r);
    return (r inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR});
  endfunction

endpackage

// File: rtl/camera_value_cfg_master.sv
// camera_value_cfg_master: AXI4-Lite master that writes a bank
// of registers, reads them back and reports pass/fail.
module camera_value_cfg_master
  import camera_value_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic start,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [3:0] err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  state_t r_state;
  state_t w_state_nx;

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_err_idx;
  logic r_pass;
  logic r_aw_done;
  logic r_w_done;
  logic [DW-1:0] r_shadow [MAX_REGS];
  logic [DW-1:0] w_cfg [MAX_REGS];

  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_sent;
  logic w_last;
  logic w_b_bad;
  logic w_r_bad;
  logic [AW-1:0] w_addr;

  // Unpack cfg_data; unused shadow slots load zero.
  for (genvar g = 0; g < MAX_REGS; g++) begin : g_cfg
    if (g < NUM_REGS) begin : g_used
      assign w_cfg[g] = cfg_data[g*DW +: DW];
    end else begin : g_free
      assign w_cfg[g] = '0;
    end
  end

  assign w_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign w_wr_sent = (r_aw_done || w_aw_hs) &&
                     (r_w_done || w_w_hs);
  assign w_last    = (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_b_bad   = resp_fail(M_AXI_BRESP);
  assign w_r_bad   = resp_fail(M_AXI_RRESP) ||
                     (M_AXI_RDATA != r_shadow[r_idx]);
  assign w_addr    = BASE_ADDR +
                     (AW'(r_idx) * AW'(REG_STRIDE));

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; any failure jumps straight to DONE.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (w_wr_sent) w_state_nx = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (w_b_bad)     w_state_nx = ST_DONE;
          else if (w_last) w_state_nx = ST_RD_REQ;
          else             w_state_nx = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) w_state_nx = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          if (w_r_bad || w_last) w_state_nx = ST_DONE;
          else                   w_state_nx = ST_RD_REQ;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Index, handshake tracking, shadow copy and result flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_idx     <= '0;
      r_err_idx <= '0;
      r_pass    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      for (int i = 0; i < MAX_REGS; i++) r_shadow[i] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shadow  <= w_cfg;
            r_idx     <= '0;
            r_pass    <= 1'b0;
            r_err_idx <= '0;
          end
        end
        ST_WR_REQ: begin
          if (w_wr_sent) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            if (w_b_bad)     r_err_idx <= r_idx;
            else if (w_last) r_idx     <= '0;
            else             r_idx     <= r_idx + 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (M_AXI_RVALID) begin
            if (w_r_bad)     r_err_idx <= r_idx;
            else if (w_last) r_pass    <= 1'b1;
            else             r_idx     <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and status outputs decoded from state; idle buses read 0.
  always_comb begin
    M_AXI_AWVALID = (r_state == ST_WR_REQ) && !r_aw_done;
    M_AXI_WVALID  = (r_state == ST_WR_REQ) && !r_w_done;
    M_AXI_BREADY  = (r_state == ST_WR_RESP);
    M_AXI_ARVALID = (r_state == ST_RD_REQ);
    M_AXI_RREADY  = (r_state == ST_RD_RESP);
    M_AXI_AWADDR  = M_AXI_AWVALID ? w_addr : '0;
    M_AXI_ARADDR  = M_AXI_ARVALID ? w_addr : '0;
    M_AXI_WDATA   = M_AXI_WVALID ? r_shadow[r_idx] : '0;
    M_AXI_WSTRB   = M_AXI_WVALID ? '1 : '0;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_ARPROT  = 3'b000;
    busy          = (r_state != ST_IDLE) &&
                    (r_state != ST_DONE);
    done          = (r_state == ST_DONE);
    pass          = r_pass;
    err_idx       = r_err_idx;
  end

endmodule

// File: tb/tb_camera_value_cfg_master.sv
// tb_camera_value_cfg_master: directed bench with a configurable
// AXI4-Lite slave model (delays, error injection, corruption).
module tb_camera_value_cfg_master;

  localparam int BOUND = 2000;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic start = 1'b0;
  logic [127:0] cfg_data = '0;
  logic busy, done, pass;
  logic [3:0] err_idx;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 aclk = ~aclk;

  camera_value_cfg_master dut (
    .ACLK(aclk), .ARESET(areset),
    .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .pass(pass), .err_idx(err_idx),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int mode = 0;
  logic [3:0] bad_b = 4'hF;
  logic [3:0] bad_r = 4'hF;

  logic [31:0] mem [16];
  logic [31:0] aw_log [16];
  logic [31:0] w_log [16];
  int n_aw, n_w, n_ar;
  int aw_wait, w_wait, ar_wait;
  int b_d, b_cnt, r_d, r_cnt;
  logic b_pend, r_pend, got_aw, got_w;
  logic [31:0] aw_addr_l, w_data_l;
  logic aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wa, wd;

  function automatic int dly();
    return (mode == 0) ? 0 : int'($urandom_range(0, 5));
  endfunction
  function automatic int dly_aw();
    if (mode == 0 || mode == 2) return 0;
    if (mode == 3) return int'($urandom_range(1, 5));
    return int'($urandom_range(0, 5));
  endfunction
  function automatic int dly_w();
    if (mode == 0 || mode == 3) return 0;
    if (mode == 2) return int'($urandom_range(1, 5));
    return int'($urandom_range(0, 5));
  endfunction

  assign awready = awvalid && (aw_wait == 0);
  assign wready  = wvalid && (w_wait == 0);
  assign arready = arvalid && (ar_wait == 0);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign wa      = aw_hs ? awaddr : aw_addr_l;
  assign wd      = w_hs ? wdata : w_data_l;
  assign wr_fire = (aw_hs || got_aw) && (w_hs || got_w);

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_wait <= dly_aw(); w_wait <= dly_w(); ar_wait <= dly();
      b_d <= dly(); r_d <= dly(); b_cnt <= 0; r_cnt <= 0;
      b_pend <= 1'b0; r_pend <= 1'b0;
      got_aw <= 1'b0; got_w <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      n_aw <= 0; n_w <= 0; n_ar <= 0;
    end else begin
      if (awvalid && aw_wait != 0) aw_wait <= aw_wait - 1;
      if (wvalid && w_wait != 0) w_wait <= w_wait - 1;
      if (arvalid && ar_wait != 0) ar_wait <= ar_wait - 1;
      if (aw_hs) begin
        aw_wait <= dly_aw(); got_aw <= 1'b1; aw_addr_l <= awaddr;
        aw_log[n_aw[3:0]] <= awaddr; n_aw <= n_aw + 1;
      end
      if (w_hs) begin
        w_wait <= dly_w(); got_w <= 1'b1; w_data_l <= wdata;
        w_log[n_w[3:0]] <= wdata; n_w <= n_w + 1;
      end
      if (wr_fire) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        mem[wa[5:2]] <= wd;
        bresp <= (wa[5:2] == bad_b) ? 2'b10 : 2'b00;
        if (b_d == 0) bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= b_d; end
        b_d <= dly();
      end else if (b_pend) begin
        if (b_cnt == 1) begin bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        ar_wait <= dly(); n_ar <= n_ar + 1; rresp <= 2'b00;
        rdata <= (araddr[5:2] == bad_r) ? 32'hDEAD_BEEF
                                        : mem[araddr[5:2]];
        if (r_d == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= r_d; end
        r_d <= dly();
      end else if (r_pend) begin
        if (r_cnt == 1) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Stall monitor: a stalled VALID must hold with stable payload.
  int n_unstable = 0;
  logic p_aw, p_w, p_ar;
  logic [31:0] p_awa, p_wd, p_ara;
  always @(posedge aclk) begin
    if (areset) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      if ((p_aw && !(awvalid && awaddr == p_awa)) ||
          (p_w && !(wvalid && wdata == p_wd)) ||
          (p_ar && !(arvalid && araddr == p_ara)))
        n_unstable <= n_unstable + 1;
      p_aw <= awvalid && !awready; p_awa <= awaddr;
      p_w  <= wvalid && !wready;   p_wd  <= wdata;
      p_ar <= arvalid && !arready; p_ara <= araddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int m);
    areset = 1'b1; mode = m;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  // Starts at a negedge; cyc counts cycles after the start cycle.
  task automatic run_cfg(input logic [127:0] cfg,
                         output int cyc, output logic busy1);
    cfg_data = cfg; start = 1'b1;
    @(negedge aclk);
    start = 1'b0; cyc = 1; busy1 = busy;
    while (!done && cyc < BOUND) begin
      @(negedge aclk); cyc++;
    end
    chk("run_done", {31'd0, done}, 32'd1);
  endtask

  int cyc, cyc2;
  logic b1;
  localparam logic [127:0] CFG_A = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] CFG_B =
    {32'hCAFE_0003, 32'h1234_5678, 32'hA5A5_5A5A, 32'h0000_FFFF};
  localparam logic [127:0] CFG_C =
    {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444};

  initial begin
    // Reset state
    mode = 0;
    repeat (2) @(negedge aclk);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid,
        bready, rready}, 32'd0);
    chk("rst_status", {28'd0, busy, done, pass, |err_idx}, 32'd0);
    chk("rst_addr", awaddr | araddr | wdata, 32'd0);
    areset = 1'b0;
    @(negedge aclk);

    // Zero-wait slave, {4,3,2,1}
    do_reset(0);
    run_cfg(CFG_A, cyc, b1);
    chk("zw_cycles", cyc, 17);
    chk("zw_busy1", {31'd0, b1}, 32'd1);
    chk("zw_pass", {31'd0, pass}, 32'd1);
    chk("zw_err", {28'd0, err_idx}, 32'd0);
    chk("zw_naw", n_aw, 4);
    chk("zw_nar", n_ar, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("zw_awaddr%0d", i), aw_log[i], 32'(4 * i));
      chk($sformatf("zw_wdata%0d", i), w_log[i], 32'(i + 1));
    end
    @(negedge aclk);
    chk("zw_done_pulse", {30'd0, done, busy}, 32'd0);
    chk("zw_pass_hold", {31'd0, pass}, 32'd1);

    // Random delays, then AW-first and W-first biased
    for (int m = 1; m <= 3; m++) begin
      do_reset(m);
      run_cfg(CFG_B, cyc, b1);
      chk($sformatf("rnd%0d_pass", m), {31'd0, pass}, 32'd1);
      chk($sformatf("rnd%0d_mem3", m), mem[3], 32'hCAFE_0003);
      chk($sformatf("rnd%0d_nar", m), n_ar, 4);
    end
    chk("stable_valid", n_unstable, 0);

    // SLVERR on register 2
    bad_b = 4'd2;
    do_reset(0);
    run_cfg(CFG_C, cyc, b1);
    chk("slv_pass", {31'd0, pass}, 32'd0);
    chk("slv_err", {28'd0, err_idx}, 32'd2);
    chk("slv_naw", n_aw, 3);
    chk("slv_nar", n_ar, 0);
    bad_b = 4'hF;

    // Readback of register 3 corrupted
    bad_r = 4'd3;
    do_reset(0);
    run_cfg(CFG_A, cyc, b1);
    chk("cor_cycles", cyc, 17);
    chk("cor_pass", {31'd0, pass}, 32'd0);
    chk("cor_err", {28'd0, err_idx}, 32'd3);
    chk("cor_nar", n_ar, 4);
    bad_r = 4'hF;

    // Second start pulse while busy is ignored
    do_reset(0);
    cfg_data = CFG_B; start = 1'b1;
    @(negedge aclk);
    start = 1'b0; cyc = 1;
    while (!done && cyc < BOUND) begin
      @(negedge aclk); cyc++;
      if (cyc == 3) begin cfg_data = CFG_C; start = 1'b1; end
      if (cyc == 4) start = 1'b0;
    end
    chk("dbl_cycles", cyc, 17);
    chk("dbl_mem0", mem[0], 32'h0000_FFFF);
    repeat (5) @(negedge aclk);
    chk("dbl_idle", {31'd0, busy}, 32'd0);
    chk("dbl_naw", n_aw, 4);

    // start held high through DONE
    do_reset(0);
    cfg_data = CFG_A; start = 1'b1;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end
    while (!done && cyc < BOUND);
    chk("hold_cycles1", cyc, 17);
    chk("hold_mem2a", mem[2], 32'd3);
    cfg_data = CFG_C;
    @(negedge aclk);
    chk("hold_idle", {30'd0, busy, done}, 32'd0);
    @(negedge aclk);
    start = 1'b0; cyc2 = 1;
    chk("hold_busy", {31'd0, busy}, 32'd1);
    while (!done && cyc2 < BOUND) begin
      @(negedge aclk); cyc2++;
    end
    chk("hold_cycles2", cyc2, 17);
    chk("hold_mem2c", mem[2], 32'h6666_6666);
    chk("hold_pass", {31'd0, pass}, 32'd1);

    // Asynchronous reset mid-write
    do_reset(3);
    cfg_data = CFG_B; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    @(negedge aclk);
    chk("ar_awvalid_pre", {31'd0, awvalid}, 32'd1);
    areset = 1'b1; mode = 0;
    #1;
    chk("ar_valids", {27'd0, awvalid, wvalid, arvalid,
        bready, rready}, 32'd0);
    chk("ar_status", {28'd0, busy, done, pass, |err_idx}, 32'd0);
    chk("ar_addr", awaddr | wdata | {28'd0, wstrb}, 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    run_cfg(CFG_A, cyc, b1);
    chk("ar_rerun_cycles", cyc, 17);
    chk("ar_rerun_pass", {31'd0, pass}, 32'd1);
    chk("ar_rerun_err", {28'd0, err_idx}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
